// File: rtl/ex_div_pkg.sv
// Shared opcodes, operation class, widths and FSM encoding for the
// iterative divide unit.
package ex_div_pkg;

    localparam int REG_LEN     = 5;
    localparam int OP_CODE_LEN = 8;
    localparam int OP_SEL_LEN  = 3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [OP_CODE_LEN-1:0] OP_DIV  = 8'h15;
    localparam logic [OP_CODE_LEN-1:0] OP_DIVU = 8'h16;
    localparam logic [OP_CODE_LEN-1:0] OP_REM  = 8'h17;
    localparam logic [OP_CODE_LEN-1:0] OP_REMU = 8'h18;

    localparam logic [OP_SEL_LEN-1:0] SEL_MULDIV = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_div_op(input logic [OP_CODE_LEN-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// Radix-2 restoring divider datapath on unsigned magnitudes: one quotient
// bit per step, MSB first. Outputs show the values after the current step.
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_step,
    output logic [31:0] rem_step
);

    logic [31:0] quo_q, rem_q, dsr_q;
    logic [32:0] shifted, diff;

    // Partial remainder stays below the divisor, so 33 bits hold the shift.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dsr_q};
    assign rem_step = 32'(diff[32] ? shifted : diff);
    assign quo_step = {quo_q[30:0], ~diff[32]};

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
        end else if (step) begin
            quo_q <= quo_step;
            rem_q <= rem_step;
        end
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU/REM/REMU execution unit: FSM, sign handling and
// special cases around the div_core restoring datapath.
module ex_div
    import ex_div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic [31:0]            ex_reg1,
    input  logic [31:0]            ex_reg2,
    input  logic [REG_LEN-1:0]     ex_rd,
    input  logic                   ex_rd_enable,
    input  logic [OP_CODE_LEN-1:0] ex_aluop,
    input  logic [OP_SEL_LEN-1:0]  ex_alusel,
    output logic                   stall_req,
    output logic                   div_done,
    output logic [31:0]            div_result,
    output logic [REG_LEN-1:0]     div_rd,
    output logic                   div_rd_enable
);

    state_t                 state, state_nxt;
    logic [4:0]             cnt;
    logic [OP_CODE_LEN-1:0] aluop_q;
    logic                   neg_q, neg_r;
    logic [REG_LEN-1:0]     rd_q;
    logic                   rd_en_q;
    logic [31:0]            result_q;

    logic        start, sgn, div_zero, ovf, special, last;
    logic [31:0] abs_a, abs_b, special_res, quo_step, rem_step, q_fix, r_fix;

    assign start = (state == ST_IDLE) && (ex_alusel == SEL_MULDIV) && is_div_op(ex_aluop)
                   && rdy && !flush;
    assign sgn      = (ex_aluop == OP_DIV) || (ex_aluop == OP_REM);
    assign abs_a    = (sgn && ex_reg1[31]) ? -ex_reg1 : ex_reg1;
    assign abs_b    = (sgn && ex_reg2[31]) ? -ex_reg2 : ex_reg2;
    assign div_zero = (ex_reg2 == ZERO_WORD);
    assign ovf      = sgn && (ex_reg1 == 32'h8000_0000) && (ex_reg2 == 32'hFFFF_FFFF);
    assign special  = div_zero || ovf;

    always_comb begin
        special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        if ((ex_aluop == OP_REM) || (ex_aluop == OP_REMU))
            special_res = div_zero ? ex_reg1 : ZERO_WORD;
    end

    div_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (start && !special),
        .step     (rdy && (state == ST_CALC)),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quo_step (quo_step),
        .rem_step (rem_step)
    );

    assign q_fix = neg_q ? -quo_step : quo_step;
    assign r_fix = neg_r ? -rem_step : rem_step;
    assign last  = (state == ST_CALC) && (cnt == 5'd31);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_CALC;
            ST_CALC: if (flush) state_nxt = ST_IDLE;
                     else if (cnt == 5'd31) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            aluop_q  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rd_q     <= '0;
            rd_en_q  <= 1'b0;
            result_q <= ZERO_WORD;
        end else if (rdy) begin
            state <= state_nxt;
            if (start) begin
                cnt     <= '0;
                aluop_q <= ex_aluop;
                neg_q   <= sgn && (ex_reg1[31] ^ ex_reg2[31]);
                neg_r   <= sgn && ex_reg1[31];
                rd_q    <= ex_rd;
                rd_en_q <= ex_rd_enable;
                if (special) result_q <= special_res;
            end else if (state == ST_CALC) begin
                cnt <= cnt + 5'd1;
            end
            // Final step result is captured as the FSM enters DONE.
            if (last && !flush)
                result_q <= ((aluop_q == OP_REM) || (aluop_q == OP_REMU)) ? r_fix : q_fix;
        end
    end

    assign stall_req     = start || (state == ST_CALC);
    assign div_done      = (state == ST_DONE);
    assign div_result    = result_q;
    assign div_rd        = rd_q;
    assign div_rd_enable = div_done && rd_en_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed and random divides compared
// against an arithmetic reference, plus rdy/flush/reset disturbances.
module tb_ex_div;
    import ex_div_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, rdy, flush;
    logic [31:0]            ex_reg1, ex_reg2;
    logic [REG_LEN-1:0]     ex_rd;
    logic                   ex_rd_enable;
    logic [OP_CODE_LEN-1:0] ex_aluop;
    logic [OP_SEL_LEN-1:0]  ex_alusel;
    logic                   stall_req, div_done, div_rd_enable;
    logic [31:0]            div_result;
    logic [REG_LEN-1:0]     div_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_rd(ex_rd),
        .ex_rd_enable(ex_rd_enable), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .stall_req(stall_req), .div_done(div_done), .div_result(div_result),
        .div_rd(div_rd), .div_rd_enable(div_rd_enable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {special, result} straight from the arithmetic rules.
    function automatic logic [32:0] ref_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic   is_rem, sgn;
        longint sa, sb;
        is_rem = (op == OP_REM) || (op == OP_REMU);
        sgn    = (op == OP_DIV) || (op == OP_REM);
        if (b == 0) return {1'b1, is_rem ? a : 32'hFFFF_FFFF};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, is_rem ? 32'h0 : 32'h8000_0000};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return {1'b0, is_rem ? 32'(sa % sb) : 32'(sa / sb)};
        end
        return {1'b0, is_rem ? a % b : a / b};
    endfunction

    // mode: 0 plain, 1 rdy low 5 cycles at iteration 10, 2 flush at it. 10, 3 rst at it. 10
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rde, input int mode);
        logic [32:0] r;
        int          exp_lat, first, n_done;
        bit          exp_stall;
        r       = ref_model(op, a, b);
        exp_lat = r[32] ? 1 : (mode == 1 ? 38 : 33);
        first   = -1;
        n_done  = 0;
        @(posedge clk); #1;
        ex_aluop = op; ex_alusel = SEL_MULDIV; ex_reg1 = a; ex_reg2 = b;
        ex_rd = rd; ex_rd_enable = rde;
        @(negedge clk);
        check("stall_at_start", stall_req, 1);
        check("no_done_at_start", div_done, 0);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (mode == 1 && c == 11) rdy = 1'b0;
            if (mode == 1 && c == 16) rdy = 1'b1;
            if (mode == 2 && c == 11) begin flush = 1'b1; ex_alusel = '0; end
            if (mode == 2 && c == 12) flush = 1'b0;
            if (mode == 3 && c == 11) begin rst = 1'b1; ex_alusel = '0; end
            if (mode == 3 && c == 12) rst = 1'b0;
            if (first >= 0 && c == first + 1) ex_alusel = '0;
            @(negedge clk);
            exp_stall = (mode >= 2) ? (c <= 11) : (c < exp_lat);
            check($sformatf("stall_c%0d", c), stall_req, exp_stall);
            if (div_done) begin
                n_done++;
                if (first < 0) begin
                    first = c;
                    check("latency", c, exp_lat);
                    check($sformatf("result_op%0h", op), div_result, r[31:0]);
                    check("div_rd", div_rd, rd);
                    check("div_rd_enable", div_rd_enable, rde);
                end
            end else begin
                check("rd_en_idle", div_rd_enable, 0);
            end
            if (mode == 3 && c == 12) begin
                check("rst_result", div_result, 0);
                check("rst_rd", div_rd, 0);
                check("rst_rd_en", div_rd_enable, 0);
            end
        end
        check("done_count", n_done, (mode >= 2) ? 0 : 1);
        ex_alusel = '0;
    endtask

    initial begin
        logic [7:0]  ops [4];
        logic [31:0] a, b;
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ex_reg1 = '0; ex_reg2 = '0; ex_rd = '0; ex_rd_enable = 1'b0;
        ex_aluop = '0; ex_alusel = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_done", div_done, 0);
        check("reset_result", div_result, 0);
        check("reset_rd", div_rd, 0);
        check("reset_rd_en", div_rd_enable, 0);
        check("reset_stall", stall_req, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_op(OP_DIVU, 100, 7, 5'd3, 1'b1, 0);
        run_op(OP_REMU, 100, 7, 5'd4, 1'b1, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 2, 5'd5, 1'b1, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 2, 5'd6, 1'b0, 0);
        run_op(OP_DIVU, 5, 0, 5'd7, 1'b1, 0);
        run_op(OP_REMU, 5, 0, 5'd8, 1'b1, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 1, 5'd11, 1'b1, 0);
        run_op(OP_DIV, 1234567, 32'hFFFF_FF85, 5'd12, 1'b1, 1);
        run_op(OP_DIVU, 1000, 3, 5'd13, 1'b1, 2);
        run_op(OP_REMU, 1000, 3, 5'd14, 1'b1, 3);

        // Flush together with a valid start must not start.
        @(posedge clk); #1;
        ex_aluop = OP_DIVU; ex_alusel = SEL_MULDIV; ex_reg1 = 9; ex_reg2 = 2; flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", stall_req, 0);
        @(posedge clk); #1 flush = 1'b0; ex_alusel = '0;
        @(negedge clk);
        check("flush_start_done", div_done, 0);
        check("flush_start_stall2", stall_req, 0);

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ops[$urandom_range(0, 3)], a, b, 5'($urandom), 1'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
